mapinfo_regbank: RTL and testbench
==================================

Name: mapinfo_regbank

Overview:
- Parametrised VME-side register bank with map-information registers.
- Provides NUM_REGS read/write 32-bit control registers, two constant identification words (map version, ident code) and an error-status register.
- Unmapped accesses complete with an error response; every error is counted and its address captured.
- Sits directly behind the VME slave decoder. Input and output pipelining are selectable per instance.

Parameters:
- ADDR_WIDTH, 20, byte-address width; the address port is word-addressed as [ADDR_WIDTH-1:2].
- NUM_REGS, 4, number of control registers, legal range 1..16.
- MAPVER, 32'h00010203, constant returned by the map-version register.
- ICODE, 32'h00000011, constant returned by the ident-code register.
- RESET_VAL, 32'h00000000, reset value of every control register.
- PIPE_IN, 1, 1 = register the write request, address and data before decode; 0 = decode directly from the port.
- PIPE_OUT, 1, 1 = register read data and read done; 0 = drive them combinationally.

Ports:
- Clk  in  1  single clock; all logic is on the rising edge.
- Rst  in  1  synchronous, active-high reset.
- VMEAddr  in  ADDR_WIDTH-2  word address.
- VMERdData  out  32  read data.
- VMEWrData  in  32  write data.
- VMERdMem  in  1  read request, one-cycle pulse.
- VMEWrMem  in  1  write request, one-cycle pulse.
- VMERdDone  out  1  read acknowledge, one-cycle pulse.
- VMEWrDone  out  1  write acknowledge, one-cycle pulse.
- VMERdError  out  1  read error, qualifies VMERdDone.
- VMEWrError  out  1  write error, qualifies VMEWrDone.
- ctrl_o  out  32*NUM_REGS  control register contents; register k occupies bits [32k+31:32k].
- wr_stb_o  out  NUM_REGS  one-cycle pulse in the cycle after register k is written.

Behaviour:
- Address map (word offsets):
  - 0..NUM_REGS-1: control registers, read/write.
  - NUM_REGS: MAPVER, read-only.
  - NUM_REGS+1: ICODE, read-only.
  - NUM_REGS+2: ERRSTAT, read; any write clears it.
  - All other offsets are unmapped.
- Reset: while Rst=1 (synchronous), all of the following are 0: Done, Error, wr_stb_o, VMERdData, pipeline registers, ERRSTAT. ctrl_o = RESET_VAL for every register.
- Reset mid-transaction: the transaction is dropped and no Done is issued. The master must re-issue it.
- Write path:
  - The request is sampled from the port (PIPE_IN=0) or from the stage-0 registers (PIPE_IN=1).
  - Control register k loads the write data on the decode cycle.
  - Its wack register rises the following cycle and drives VMEWrDone and wr_stb_o[k] together.
  - Every write completes with VMEWrDone exactly PIPE_IN+1 cycles after VMEWrMem, whatever the target; Done is delayed by one cycle where needed so the latency is uniform.
  - Writes to MAPVER/ICODE are acknowledged with no error and no effect.
  - Writes to ERRSTAT are acknowledged and clear it to 0.
  - Writes to unmapped offsets assert VMEWrDone and VMEWrError together.
- Read path:
  - Decoding is always taken from the live VMEAddr.
  - VMERdDone follows VMERdMem after PIPE_OUT cycles (0 = same cycle).
  - Unmapped reads return data 0 and assert VMERdError together with VMERdDone.
  - On non-done cycles, VMERdData holds its last value.
- ERRSTAT layout:
  - [15:0]: error count. Increments on each VMERdError or VMEWrError pulse and saturates at 16'hFFFF.
  - [29:16]: low 14 bits of the word address of the last error.
  - [30]: 1 = last error was a write.
  - [31]: sticky any-error flag.
- Simultaneous events:
  - Read error and write error in the same cycle: count +2 (saturating); the write's address and bit30=1 win.
  - Clear (write to ERRSTAT) and an error in the same cycle: the clear happens first, then the error is recorded, so count=1.
- Read and write concurrency:
  - VMERdMem and VMEWrMem in the same cycle are both served independently.
  - A read and a write to the same register in the same decode cycle return the old value.
- One outstanding transaction per direction. A new request of the same type before the previous Done is a protocol violation; behaviour is unspecified.

Test Plan:
- Reset with NUM_REGS=4, RESET_VAL=32'hA5A5A5A5 → ctrl_o = 4×32'hA5A5A5A5; reading offset 5 returns 32'h00000011 with no error.
- PIPE_IN=1: write 32'hDEADBEEF to offset 2 at cycle 0 → VMEWrDone and wr_stb_o[2] at cycle 2; ctrl_o[95:64] = 32'hDEADBEEF; readback matches with Done at cycle PIPE_OUT.
- PIPE_OUT=0 and PIPE_OUT=1: read offset 4 → 32'h00010203 at cycle 0 and cycle 1 respectively; a write to offset 4 is acknowledged with no error and the value is unchanged.
- Read offset 9, then write offset 200 → each Done has its Error flag set; ERRSTAT = count 2, address 200, bit30=1, bit31=1; a write to ERRSTAT then reads back 0.
- Force 65537 unmapped reads → count stays at 16'hFFFF; assert Rst mid-write → no VMEWrDone, ERRSTAT=0, ctrl_o = RESET_VAL.
- Same-cycle write-error and read-error → count +2; clear concurrent with an error → count=1.

Source files
------------

// File: rtl/mapinfo_regbank_if.sv
// VME slave-side bus bundle for mapinfo_regbank: request, address, data and
// the done/error acknowledge signals.
interface mapinfo_regbank_if #(
    parameter int ADDR_WIDTH = 20
);
    logic [ADDR_WIDTH-1:2] VMEAddr;
    logic [31:0]           VMERdData;
    logic [31:0]           VMEWrData;
    logic                  VMERdMem;
    logic                  VMEWrMem;
    logic                  VMERdDone;
    logic                  VMEWrDone;
    logic                  VMERdError;
    logic                  VMEWrError;

    modport master (
        output VMEAddr, VMEWrData, VMERdMem, VMEWrMem,
        input  VMERdData, VMERdDone, VMEWrDone, VMERdError, VMEWrError
    );

    modport slave (
        input  VMEAddr, VMEWrData, VMERdMem, VMEWrMem,
        output VMERdData, VMERdDone, VMEWrDone, VMERdError, VMEWrError
    );
endinterface

// File: rtl/mapinfo_regbank.sv
// VME register bank: NUM_REGS control registers, constant map-version and
// ident words, and an error-status register that counts unmapped accesses.
module mapinfo_regbank #(
    parameter int          ADDR_WIDTH = 20,
    parameter int          NUM_REGS   = 4,
    parameter logic [31:0] MAPVER     = 32'h00010203,
    parameter logic [31:0] ICODE      = 32'h00000011,
    parameter logic [31:0] RESET_VAL  = 32'h00000000,
    parameter int          PIPE_IN    = 1,
    parameter int          PIPE_OUT   = 1
) (
    input  logic                      Clk,
    input  logic                      Rst,
    mapinfo_regbank_if.slave          vme,
    output logic [32*NUM_REGS-1:0]    ctrl_o,
    output logic [NUM_REGS-1:0]       wr_stb_o
);
    localparam logic [31:0] OFS_MAPVER  = 32'(NUM_REGS);
    localparam logic [31:0] OFS_ICODE   = 32'(NUM_REGS + 1);
    localparam logic [31:0] OFS_ERRSTAT = 32'(NUM_REGS + 2);

    logic [31:0]         ctrl_q [NUM_REGS];
    logic [31:0]         errstat_q;
    logic [31:0]         errstat_d;
    logic [16:0]         err_inc;
    logic [16:0]         cnt_sum;

    logic                wr_req_d;
    logic [31:0]         wr_addr_d;
    logic [31:0]         wr_data_d;
    logic [NUM_REGS-1:0] wr_sel;
    logic                wr_clr;
    logic                wr_err_evt;
    logic [NUM_REGS-1:0] wr_stb_q;
    logic                wr_done_q;
    logic                wr_err_q;

    logic [31:0]         rd_addr;
    logic [31:0]         rd_data_c;
    logic                rd_unmapped;
    logic                rd_fire;
    logic                rd_err_evt;

    generate
        if (PIPE_IN != 0) begin : g_pipe_in
            logic        wr_req_q;
            logic [31:0] wr_addr_q;
            logic [31:0] wr_data_q;
            // Stage-0 capture of the write request ahead of decode.
            always_ff @(posedge Clk) begin
                if (Rst) begin
                    wr_req_q  <= 1'b0;
                    wr_addr_q <= '0;
                    wr_data_q <= '0;
                end else begin
                    wr_req_q  <= vme.VMEWrMem;
                    wr_addr_q <= 32'(vme.VMEAddr);
                    wr_data_q <= vme.VMEWrData;
                end
            end
            assign wr_req_d  = wr_req_q;
            assign wr_addr_d = wr_addr_q;
            assign wr_data_d = wr_data_q;
        end else begin : g_no_pipe_in
            assign wr_req_d  = vme.VMEWrMem;
            assign wr_addr_d = 32'(vme.VMEAddr);
            assign wr_data_d = vme.VMEWrData;
        end
    endgenerate

    // Write decode: control-register select, ERRSTAT clear, unmapped error.
    always_comb begin
        wr_sel = '0;
        for (int unsigned k = 0; k < NUM_REGS; k++) begin
            if (wr_req_d && wr_addr_d == 32'(k)) wr_sel[k] = 1'b1;
        end
        wr_clr     = wr_req_d && (wr_addr_d == OFS_ERRSTAT);
        wr_err_evt = wr_req_d && (wr_addr_d > OFS_ERRSTAT);
    end

    // Control registers load on decode; every write is acked one cycle later
    // so the latency is the same for all targets.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int unsigned k = 0; k < NUM_REGS; k++) ctrl_q[k] <= RESET_VAL;
            wr_stb_q  <= '0;
            wr_done_q <= 1'b0;
            wr_err_q  <= 1'b0;
        end else begin
            for (int unsigned k = 0; k < NUM_REGS; k++) begin
                if (wr_sel[k]) ctrl_q[k] <= wr_data_d;
            end
            wr_stb_q  <= wr_sel;
            wr_done_q <= wr_req_d;
            wr_err_q  <= wr_err_evt;
        end
    end

    assign vme.VMEWrDone  = wr_done_q;
    assign vme.VMEWrError = wr_err_q;
    assign wr_stb_o       = wr_stb_q;

    // Pack the control registers onto the flat output bus.
    always_comb begin
        ctrl_o = '0;
        for (int unsigned k = 0; k < NUM_REGS; k++) ctrl_o[32*k +: 32] = ctrl_q[k];
    end

    assign rd_addr    = 32'(vme.VMEAddr);
    assign rd_fire    = vme.VMERdMem & ~Rst;
    assign rd_err_evt = rd_fire & rd_unmapped;

    // Read mux from the live address; unmapped offsets return 0.
    always_comb begin
        rd_data_c   = '0;
        rd_unmapped = 1'b0;
        if (rd_addr < OFS_MAPVER) begin
            for (int unsigned k = 0; k < NUM_REGS; k++) begin
                if (rd_addr == 32'(k)) rd_data_c = ctrl_q[k];
            end
        end else if (rd_addr == OFS_MAPVER) begin
            rd_data_c = MAPVER;
        end else if (rd_addr == OFS_ICODE) begin
            rd_data_c = ICODE;
        end else if (rd_addr == OFS_ERRSTAT) begin
            rd_data_c = errstat_q;
        end else begin
            rd_unmapped = 1'b1;
        end
    end

    generate
        if (PIPE_OUT != 0) begin : g_pipe_out
            logic [31:0] rd_data_q;
            logic        rd_done_q;
            logic        rd_err_q;
            // Registered read response; data holds between reads.
            always_ff @(posedge Clk) begin
                if (Rst) begin
                    rd_data_q <= '0;
                    rd_done_q <= 1'b0;
                    rd_err_q  <= 1'b0;
                end else begin
                    rd_done_q <= rd_fire;
                    rd_err_q  <= rd_err_evt;
                    if (rd_fire) rd_data_q <= rd_data_c;
                end
            end
            assign vme.VMERdData  = rd_data_q;
            assign vme.VMERdDone  = rd_done_q;
            assign vme.VMERdError = rd_err_q;
        end else begin : g_no_pipe_out
            logic [31:0] rd_hold_q;
            // Last returned data, shown on cycles without a read.
            always_ff @(posedge Clk) begin
                if (Rst) rd_hold_q <= '0;
                else if (rd_fire) rd_hold_q <= rd_data_c;
            end
            assign vme.VMERdData  = Rst ? '0 : (rd_fire ? rd_data_c : rd_hold_q);
            assign vme.VMERdDone  = rd_fire;
            assign vme.VMERdError = rd_err_evt;
        end
    endgenerate

    // Errors are logged on their decode cycle: clear first, then add up to
    // two events with saturation; a write error's address wins.
    always_comb begin
        errstat_d = wr_clr ? '0 : errstat_q;
        err_inc   = 17'(rd_err_evt) + 17'(wr_err_evt);
        cnt_sum   = 17'(errstat_d[15:0]) + err_inc;
        if (rd_err_evt || wr_err_evt) begin
            errstat_d[15:0] = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
            errstat_d[31]   = 1'b1;
            if (wr_err_evt) begin
                errstat_d[30]    = 1'b1;
                errstat_d[29:16] = wr_addr_d[13:0];
            end else begin
                errstat_d[30]    = 1'b0;
                errstat_d[29:16] = rd_addr[13:0];
            end
        end
    end

    // Error-status register.
    always_ff @(posedge Clk) begin
        if (Rst) errstat_q <= '0;
        else     errstat_q <= errstat_d;
    end
endmodule

// File: tb/tb_mapinfo_regbank.sv
// Self-checking bench for mapinfo_regbank: a pipelined instance (PIPE_IN=1,
// PIPE_OUT=1) and a combinational instance (PIPE_IN=0, PIPE_OUT=0).
`timescale 1ns/1ps
module tb_mapinfo_regbank;
    localparam int          AW = 20;
    localparam logic [31:0] RV = 32'hA5A5A5A5;
    localparam logic [31:0] MV = 32'h00010203;
    localparam logic [31:0] IC = 32'h00000011;

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    always #5 Clk = ~Clk;

    mapinfo_regbank_if #(.ADDR_WIDTH(AW)) bus ();
    mapinfo_regbank_if #(.ADDR_WIDTH(AW)) bus0 ();

    logic [127:0] ctrl, ctrl0;
    logic [3:0]   stb, stb0;

    mapinfo_regbank #(.ADDR_WIDTH(AW), .NUM_REGS(4), .MAPVER(MV), .ICODE(IC),
                      .RESET_VAL(RV), .PIPE_IN(1), .PIPE_OUT(1))
        dut (.Clk(Clk), .Rst(Rst), .vme(bus), .ctrl_o(ctrl), .wr_stb_o(stb));

    mapinfo_regbank #(.ADDR_WIDTH(AW), .NUM_REGS(4), .MAPVER(MV), .ICODE(IC),
                      .RESET_VAL(RV), .PIPE_IN(0), .PIPE_OUT(0))
        dut0 (.Clk(Clk), .Rst(Rst), .vme(bus0), .ctrl_o(ctrl0), .wr_stb_o(stb0));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference model: register map semantics at transaction level.
    logic [31:0] m_ctrl [4];
    int unsigned m_cnt;
    logic [13:0] m_eaddr;
    bit          m_ewr;
    bit          m_sticky;

    function automatic void m_reset();
        for (int i = 0; i < 4; i++) m_ctrl[i] = RV;
        m_cnt = 0; m_eaddr = '0; m_ewr = 1'b0; m_sticky = 1'b0;
    endfunction

    function automatic logic [31:0] m_errstat();
        logic [15:0] c;
        c = 16'(m_cnt);
        return {m_sticky, m_ewr, m_eaddr, c};
    endfunction

    function automatic void m_record(input int unsigned a, input bit wr);
        m_cnt    = (m_cnt < 65535) ? m_cnt + 1 : 65535;
        m_eaddr  = 14'(a);
        m_ewr    = wr;
        m_sticky = 1'b1;
    endfunction

    function automatic bit m_write(input int unsigned a, input logic [31:0] d);
        if (a < 4) m_ctrl[a] = d;
        else if (a == 6) begin m_cnt = 0; m_eaddr = '0; m_ewr = 1'b0; m_sticky = 1'b0; end
        else if (a > 6) begin m_record(a, 1'b1); return 1'b1; end
        return 1'b0;
    endfunction

    function automatic bit m_read(input int unsigned a, output logic [31:0] d);
        d = '0;
        if (a < 4) d = m_ctrl[a];
        else if (a == 4) d = MV;
        else if (a == 5) d = IC;
        else if (a == 6) d = m_errstat();
        else begin m_record(a, 1'b0); return 1'b1; end
        return 1'b0;
    endfunction

    // Pipelined-instance transactions; called at a negedge, return at a negedge.
    task automatic do_write(input int unsigned a, input logic [31:0] d, output logic err);
        bus.VMEAddr = 18'(a); bus.VMEWrData = d; bus.VMEWrMem = 1'b1;
        @(negedge Clk);
        bus.VMEWrMem = 1'b0;
        chk("wr_done_early", 32'(bus.VMEWrDone), 32'd0);
        @(negedge Clk);
        chk("wr_done_lat2", 32'(bus.VMEWrDone), 32'd1);
        err = bus.VMEWrError;
        if (a < 4) chk("wr_stb", 32'(stb), 32'(4'b0001 << a));
        else       chk("wr_stb_none", 32'(stb), 32'd0);
    endtask

    task automatic do_read(input int unsigned a, output logic [31:0] d, output logic err);
        bus.VMEAddr = 18'(a); bus.VMERdMem = 1'b1;
        @(negedge Clk);
        bus.VMERdMem = 1'b0;
        chk("rd_done_lat1", 32'(bus.VMERdDone), 32'd1);
        d = bus.VMERdData; err = bus.VMERdError;
    endtask

    typedef struct {
        bit          wr;
        int unsigned addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        bit          exp_err;
    } vec_t;

    vec_t tbl [12];

    initial begin
        #5ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d, md;
        logic        e, me;
        int unsigned a;

        tbl[0]  = '{0, 5,   32'h0,        IC,            0};
        tbl[1]  = '{0, 4,   32'h0,        MV,            0};
        tbl[2]  = '{1, 2,   32'hDEADBEEF, 32'h0,         0};
        tbl[3]  = '{0, 2,   32'h0,        32'hDEADBEEF,  0};
        tbl[4]  = '{1, 4,   32'h12345678, 32'h0,         0};
        tbl[5]  = '{0, 4,   32'h0,        MV,            0};
        tbl[6]  = '{0, 9,   32'h0,        32'h0,         1};
        tbl[7]  = '{1, 200, 32'h0,        32'h0,         1};
        tbl[8]  = '{0, 6,   32'h0,        32'hC0C80002,  0};
        tbl[9]  = '{1, 6,   32'h55555555, 32'h0,         0};
        tbl[10] = '{0, 6,   32'h0,        32'h0,         0};
        tbl[11] = '{0, 0,   32'h0,        RV,            0};

        bus.VMEAddr = '0; bus.VMEWrData = '0; bus.VMERdMem = 1'b0; bus.VMEWrMem = 1'b0;
        bus0.VMEAddr = '0; bus0.VMEWrData = '0; bus0.VMERdMem = 1'b0; bus0.VMEWrMem = 1'b0;
        m_reset();

        repeat (3) @(negedge Clk);
        chk("rst_ctrl_lo", ctrl[31:0], RV);
        chk("rst_ctrl_hi", ctrl[127:96], RV);
        chk("rst_rddata", bus.VMERdData, 32'h0);
        chk("rst_done", {30'h0, bus.VMERdDone, bus.VMEWrDone}, 32'h0);
        chk("rst_stb", 32'(stb), 32'h0);
        Rst = 1'b0;
        @(negedge Clk);

        for (int i = 0; i < 12; i++) begin
            if (tbl[i].wr) begin
                do_write(tbl[i].addr, tbl[i].wdata, e);
                void'(m_write(tbl[i].addr, tbl[i].wdata));
            end else begin
                do_read(tbl[i].addr, d, e);
                void'(m_read(tbl[i].addr, md));
                chk($sformatf("vec%0d_data", i), d, tbl[i].exp_data);
            end
            chk($sformatf("vec%0d_err", i), 32'(e), 32'(tbl[i].exp_err));
        end
        chk("ctrl2_dead", ctrl[95:64], 32'hDEADBEEF);
        chk("ctrl3_rv", ctrl[127:96], RV);
        @(negedge Clk);
        chk("rd_hold", bus.VMERdData, RV);

        // Read and write of reg 1 decoded in the same cycle: read sees old value.
        bus.VMEAddr = 18'd1; bus.VMEWrData = 32'h11112222; bus.VMEWrMem = 1'b1;
        @(negedge Clk);
        bus.VMEWrMem = 1'b0; bus.VMERdMem = 1'b1;
        @(negedge Clk);
        bus.VMERdMem = 1'b0;
        chk("rw_same_wrdone", 32'(bus.VMEWrDone), 32'd1);
        chk("rw_same_rddone", 32'(bus.VMERdDone), 32'd1);
        chk("rw_same_old", bus.VMERdData, RV);
        void'(m_write(1, 32'h11112222));
        do_read(1, d, e);
        chk("rw_same_new", d, 32'h11112222);

        // ERRSTAT clear decoded together with a read error: count ends at 1.
        do_read(9, d, e);
        void'(m_read(9, md));
        bus.VMEAddr = 18'd6; bus.VMEWrMem = 1'b1;
        @(negedge Clk);
        bus.VMEWrMem = 1'b0; bus.VMEAddr = 18'd9; bus.VMERdMem = 1'b1;
        @(negedge Clk);
        bus.VMERdMem = 1'b0;
        chk("clr_err_flags", {28'h0, bus.VMEWrDone, bus.VMEWrError, bus.VMERdDone, bus.VMERdError},
            32'b1011);
        void'(m_write(6, 32'h0));
        void'(m_read(9, md));
        do_read(6, d, e);
        chk("clr_then_err", d, 32'h80090001);

        // Write error and read error decoded together: +2, write address wins.
        bus.VMEAddr = 18'd300; bus.VMEWrMem = 1'b1;
        @(negedge Clk);
        bus.VMEWrMem = 1'b0; bus.VMEAddr = 18'd77; bus.VMERdMem = 1'b1;
        @(negedge Clk);
        bus.VMERdMem = 1'b0;
        chk("dual_err_flags", {28'h0, bus.VMEWrDone, bus.VMEWrError, bus.VMERdDone, bus.VMERdError},
            32'b1111);
        void'(m_read(77, md));
        void'(m_write(300, 32'h0));
        do_read(6, d, e);
        chk("dual_err_stat", d, 32'hC12C0003);

        // Randomised transactions against the model.
        for (int n = 0; n < 300; n++) begin
            a = ($urandom_range(0, 7) == 0) ? $urandom_range(7, 5000) : $urandom_range(0, 6);
            md = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                do_write(a, md, e);
                me = m_write(a, md);
                chk("rnd_wr_err", 32'(e), 32'(me));
                for (int k = 0; k < 4; k++) chk("rnd_ctrl", ctrl[32*k +: 32], m_ctrl[k]);
            end else begin
                do_read(a, d, e);
                me = m_read(a, md);
                chk("rnd_rd_data", d, md);
                chk("rnd_rd_err", 32'(e), 32'(me));
            end
        end

        // Reset in the middle of a write: no ack, state back to reset values.
        bus.VMEAddr = 18'd1; bus.VMEWrData = 32'h0BADF00D; bus.VMEWrMem = 1'b1;
        @(negedge Clk);
        bus.VMEWrMem = 1'b0; Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk("rst_mid_nodone", 32'(bus.VMEWrDone), 32'd0);
            @(negedge Clk);
        end
        chk("rst_mid_ctrl1", ctrl[63:32], RV);
        chk("rst_mid_ctrl2", ctrl[95:64], RV);
        m_reset();
        do_read(6, d, e);
        chk("rst_mid_errstat", d, 32'h0);

        // Combinational instance: same-cycle read, one-cycle write ack.
        bus0.VMEAddr = 18'd4; bus0.VMERdMem = 1'b1;
        #1;
        chk("c_rd4_done", 32'(bus0.VMERdDone), 32'd1);
        chk("c_rd4_data", bus0.VMERdData, MV);
        chk("c_rd4_err", 32'(bus0.VMERdError), 32'd0);
        @(negedge Clk);
        bus0.VMERdMem = 1'b0;
        #1;
        chk("c_rd_idle", 32'(bus0.VMERdDone), 32'd0);
        chk("c_rd_hold", bus0.VMERdData, MV);
        bus0.VMEWrData = 32'hFFFFFFFF; bus0.VMEWrMem = 1'b1;
        #1;
        chk("c_wr_early", 32'(bus0.VMEWrDone), 32'd0);
        @(negedge Clk);
        bus0.VMEWrMem = 1'b0;
        chk("c_wr4_ack", {30'h0, bus0.VMEWrDone, bus0.VMEWrError}, 32'b10);
        bus0.VMERdMem = 1'b1;
        #1;
        chk("c_rd4_unchanged", bus0.VMERdData, MV);
        @(negedge Clk);
        bus0.VMERdMem = 1'b0;
        bus0.VMEAddr = 18'd3; bus0.VMEWrData = 32'h13579BDF; bus0.VMEWrMem = 1'b1;
        @(negedge Clk);
        bus0.VMEWrMem = 1'b0;
        chk("c_wr3_done", 32'(bus0.VMEWrDone), 32'd1);
        chk("c_wr3_stb", 32'(stb0), 32'h8);
        chk("c_wr3_ctrl", ctrl0[127:96], 32'h13579BDF);

        // 65537 back-to-back unmapped reads: the count saturates.
        bus0.VMEAddr = 18'd9; bus0.VMERdMem = 1'b1;
        #1;
        chk("c_sat_err", 32'(bus0.VMERdError), 32'd1);
        repeat (65537) @(posedge Clk);
        @(negedge Clk);
        bus0.VMERdMem = 1'b0;
        @(negedge Clk);
        bus0.VMEAddr = 18'd6; bus0.VMERdMem = 1'b1;
        #1;
        chk("c_sat_errstat", bus0.VMERdData, 32'h8009FFFF);
        @(negedge Clk);
        bus0.VMERdMem = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
